// File: rtl/seq_subtractor_32bit_if.sv
// Operand/result bus for seq_subtractor_32bit: valid/ready on the operand
// side and on the result side, plus the result flags.
// The DUT uses the slave modport and the producer/consumer uses master.
interface seq_subtractor_32bit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             overflow;
    logic             borrow;
    logic             isNotEqual;
    logic             isLessThan;

    modport slave (
        input  in_valid,
        input  data_operandA,
        input  data_operandB,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_result,
        output overflow,
        output borrow,
        output isNotEqual,
        output isLessThan
    );

    modport master (
        output in_valid,
        output data_operandA,
        output data_operandB,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_result,
        input  overflow,
        input  borrow,
        input  isNotEqual,
        input  isLessThan
    );
endinterface

// File: rtl/seq_subtractor_32bit.sv
// Multi-cycle two's-complement subtractor: A - B computed as A + ~B + 1,
// one 8-bit slice per clock, LSB slice first, carry registered between
// slices through a single shared csa_adder_8bit.
// Optional comparison flags are enabled with the macro SEQ_SUB_CMP_FLAGS_EN;
// without it isNotEqual and isLessThan are tied to 0.

// 8-bit carry-select adder: low nibble ripples, high nibble is precomputed
// for both possible nibble carries and selected by the real one.
module csa_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo_sum;
    logic [4:0] hi_sum0;
    logic [4:0] hi_sum1;

    // Both high-nibble candidates are formed in parallel with the low nibble
    always_comb begin
        lo_sum  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi_sum0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi_sum1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        if (lo_sum[4]) begin
            sum  = {hi_sum1[3:0], lo_sum[3:0]};
            cout = hi_sum1[4];
        end else begin
            sum  = {hi_sum0[3:0], lo_sum[3:0]};
            cout = hi_sum0[4];
        end
    end
endmodule

module seq_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    seq_subtractor_32bit_if.slave  bus
);
    // Slice count follows from the widths; CHUNK must stay 8 for the adder
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] slice_cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b_inv;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             borrow_q;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             last_slice;

    // Pick the current slice of the latched operands and merge its sum into
    // the partial result, so the flags can be formed from the full result
    always_comb begin
        a_slice    = op_a[int'(slice_cnt) * CHUNK +: CHUNK];
        b_slice    = op_b_inv[int'(slice_cnt) * CHUNK +: CHUNK];
        res_next   = result_q;
        res_next[int'(slice_cnt) * CHUNK +: CHUNK] = slice_sum;
        ovf_next   = (op_a[WIDTH-1] != ~op_b_inv[WIDTH-1]) &&
                     (res_next[WIDTH-1] != op_a[WIDTH-1]);
        last_slice = (slice_cnt == CNT_W'(NSLICE - 1));
    end

    csa_adder_8bit u_slice_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef SEQ_SUB_CMP_FLAGS_EN
    logic not_equal_q;
    logic less_than_q;
`endif

    // Handshake FSM plus slice datapath; flags are captured on the last slice
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            slice_cnt  <= '0;
            op_a       <= '0;
            op_b_inv   <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            borrow_q   <= 1'b0;
`ifdef SEQ_SUB_CMP_FLAGS_EN
            not_equal_q <= 1'b0;
            less_than_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a      <= bus.data_operandA;
                        op_b_inv  <= ~bus.data_operandB;
                        carry_q   <= 1'b1;
                        result_q  <= '0;
                        slice_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    result_q <= res_next;
                    carry_q  <= slice_cout;
                    if (last_slice) begin
                        slice_cnt  <= '0;
                        state      <= DONE;
                        overflow_q <= ovf_next;
                        borrow_q   <= ~slice_cout;
`ifdef SEQ_SUB_CMP_FLAGS_EN
                        not_equal_q <= |res_next;
                        less_than_q <= res_next[WIDTH-1] ^ ovf_next;
`endif
                    end else begin
                        slice_cnt <= slice_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.data_result = result_q;
    assign bus.overflow    = overflow_q;
    assign bus.borrow      = borrow_q;
`ifdef SEQ_SUB_CMP_FLAGS_EN
    assign bus.isNotEqual  = not_equal_q;
    assign bus.isLessThan  = less_than_q;
`else
    assign bus.isNotEqual  = 1'b0;
    assign bus.isLessThan  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_subtractor_32bit.sv
// Directed testbench for seq_subtractor_32bit with immediate assertions.
// Expected comparison flags depend on SEQ_SUB_CMP_FLAGS_EN being defined.
module tb_seq_subtractor_32bit;
    logic clock;
    logic reset;
    int   passCount;
    int   checkCount;

    seq_subtractor_32bit_if #(.WIDTH(32)) bus_if ();

    seq_subtractor_32bit #(.WIDTH(32), .CHUNK(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running clock, 10 time units per period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Present operands, wait (bounded) for in_ready, take the accept edge,
    // then drop in_valid and scramble the operand inputs
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b);
        int waitCycles;
        bus_if.in_valid      = 1'b1;
        bus_if.data_operandA = a;
        bus_if.data_operandB = b;
        waitCycles = 0;
        while (!bus_if.in_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (waitCycles >= 20) checkOutput({tag, "/in_ready_timeout"}, 32'(waitCycles), 32'd0);
        tick();
        bus_if.in_valid      = 1'b0;
        bus_if.data_operandA = 32'hDEAD_BEEF;
        bus_if.data_operandB = 32'h5555_AAAA;
        checkOutput({tag, "/busy_in_ready"}, 32'(bus_if.in_ready), 32'd0);
    endtask

    // Wait for out_valid (4 edges after the accept edge, i.e. the fifth cycle
    // counted from the accept cycle) and check result and flags
    task automatic checkResult(input string tag, input logic [31:0] expRes,
                               input logic expBorrow, input logic expOvf,
                               input logic expNe, input logic expLt);
        int lat;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "/result"}, bus_if.data_result, expRes);
        checkOutput({tag, "/borrow"}, 32'(bus_if.borrow), 32'(expBorrow));
        checkOutput({tag, "/overflow"}, 32'(bus_if.overflow), 32'(expOvf));
`ifdef SEQ_SUB_CMP_FLAGS_EN
        checkOutput({tag, "/isNotEqual"}, 32'(bus_if.isNotEqual), 32'(expNe));
        checkOutput({tag, "/isLessThan"}, 32'(bus_if.isLessThan), 32'(expLt));
`else
        checkOutput({tag, "/isNotEqual"}, 32'(bus_if.isNotEqual), 32'(1'b0 & expNe));
        checkOutput({tag, "/isLessThan"}, 32'(bus_if.isLessThan), 32'(1'b0 & expLt));
`endif
    endtask

    // Leave DONE with out_ready high and confirm the block is idle again
    task automatic drainResult(input string tag);
        bus_if.out_ready = 1'b1;
        tick();
        checkOutput({tag, "/idle_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        checkOutput({tag, "/idle_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    endtask

    // Linear sequence of directed steps
    initial begin
        passCount            = 0;
        checkCount           = 0;
        reset                = 1'b1;
        bus_if.in_valid      = 1'b0;
        bus_if.out_ready     = 1'b1;
        bus_if.data_operandA = '0;
        bus_if.data_operandB = '0;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst/in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("rst/out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("rst/result", bus_if.data_result, 32'd0);
        checkOutput("rst/borrow", 32'(bus_if.borrow), 32'd0);
        checkOutput("rst/overflow", 32'(bus_if.overflow), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] basic subtractions");
        applyStimulus("a_gt_b", 32'h0000_000A, 32'h0000_0003);
        checkResult("a_gt_b", 32'h0000_0007, 1'b0, 1'b0, 1'b1, 1'b0);
        drainResult("a_gt_b");

        applyStimulus("a_lt_b", 32'h0000_0003, 32'h0000_000A);
        checkResult("a_lt_b", 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b1, 1'b1);
        drainResult("a_lt_b");

        applyStimulus("min_minus1", 32'h8000_0000, 32'h0000_0001);
        checkResult("min_minus1", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);
        drainResult("min_minus1");

        applyStimulus("xslice", 32'h0001_0000, 32'h0000_0001);
        checkResult("xslice", 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        drainResult("xslice");

        applyStimulus("equal", 32'h1234_5678, 32'h1234_5678);
        checkResult("equal", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        drainResult("equal");

        applyStimulus("zero_minus1", 32'h0000_0000, 32'h0000_0001);
        checkResult("zero_minus1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        drainResult("zero_minus1");

        applyStimulus("max_minus_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        checkResult("max_minus_neg1", 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        drainResult("max_minus_neg1");

        $display("[TB] backpressure");
        bus_if.out_ready = 1'b0;
        applyStimulus("bp", 32'h0000_0100, 32'h0000_0001);
        checkResult("bp", 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_if.in_valid      = 1'b1;
        bus_if.data_operandA = 32'h0000_0050;
        bus_if.data_operandB = 32'h0000_0020;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp/hold_result", bus_if.data_result, 32'h0000_00FF);
            checkOutput("bp/hold_in_ready", 32'(bus_if.in_ready), 32'd0);
            checkOutput("bp/hold_out_valid", 32'(bus_if.out_valid), 32'd1);
        end
        bus_if.out_ready = 1'b1;
        tick();
        checkOutput("bp/release_in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("bp/release_out_valid", 32'(bus_if.out_valid), 32'd0);
        tick();
        checkOutput("bp/accepted_in_ready", 32'(bus_if.in_ready), 32'd0);
        bus_if.in_valid      = 1'b0;
        bus_if.data_operandA = 32'hFFFF_0000;
        bus_if.data_operandB = 32'h0000_FFFF;
        checkResult("bp_next", 32'h0000_0030, 1'b0, 1'b0, 1'b1, 1'b0);
        drainResult("bp_next");

        $display("[TB] reset during BUSY");
        applyStimulus("midrst", 32'h0000_0005, 32'h0000_0002);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst/in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("midrst/out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("midrst/result", bus_if.data_result, 32'd0);
        checkOutput("midrst/borrow", 32'(bus_if.borrow), 32'd0);
        checkOutput("midrst/overflow", 32'(bus_if.overflow), 32'd0);
        checkOutput("midrst/isNotEqual", 32'(bus_if.isNotEqual), 32'd0);
        checkOutput("midrst/isLessThan", 32'(bus_if.isLessThan), 32'd0);
        reset = 1'b0;
        tick();
        applyStimulus("postrst", 32'h00FF_00FF, 32'h0000_FF00);
        checkResult("postrst", 32'h00FE_01FF, 1'b0, 1'b0, 1'b1, 1'b0);
        drainResult("postrst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
